// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU and its program loader:
//   - MEM_SIZE_DEF   : default instruction memory depth in bytes
//   - loader_state_e : program-loader FSM states
//   - opcode / register-index constants used by the CPU core
//   - sum8           : modulo-256 byte sum used by the loader checksum
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int MEM_SIZE_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_e;

    // Opcode field (upper nibble of an instruction byte)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Register indices
    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

    // Modulo-256 accumulate of one byte into a running sum.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader_strobe_sync.sv
// ---------------------------------------------------------------------------
// strobe_sync
// Brings an asynchronous pin strobe into the clk domain and produces a
// single-cycle pulse for every rising edge of the strobe.
//   SYNC_STAGES-flop synchronizer -> history flop -> registered rise pulse.
// The rise pulse is registered so downstream logic sees a clean flop output.
// A strobe first sampled high at clk edge 1 gives o_rise high after edge
// SYNC_STAGES+1.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   i_async  in  asynchronous strobe pin
//   o_rise   out one-cycle pulse per rising edge of i_async
// ---------------------------------------------------------------------------
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_rise;

    // Synchronizer chain, edge history and registered rise pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Streams a program from the host pins into instruction memory and holds
// the CPU (PC forced to 0) while loading. Session format: one length byte
// (0 means 256), then len data bytes written to addresses 0..len-1
// (wrapping modulo MEM_SIZE).
// Build option: define LOADER_CHECKSUM_EN to require a trailing checksum
// byte (two's complement of the data-byte sum); a bad checksum ends in ERR.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_req     level, high starts and sustains a load session
//   byte_in      program byte, stable while byte_strobe is high
//   byte_strobe  asynchronous strobe, one byte per rising edge
//   mem_we       one-cycle write pulse to instruction memory
//   mem_addr     write address (ADDR_W bits)
//   mem_wdata    write data
//   cpu_hold     high = CPU frozen
//   load_done    high after a successful load until the next session
//   load_err     sticky error, cleared when the next session starts
// ---------------------------------------------------------------------------
module prog_loader
    import cpu_pkg::*;
#(
    parameter int MEM_SIZE    = MEM_SIZE_DEF,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_strobe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [8:0] ADDR_MASK = 9'(MEM_SIZE - 1);

    loader_state_e     r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_wdata, w_wdata_nxt;
    logic              r_hold, w_hold_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [8:0]        r_count, w_count_nxt;
    logic [8:0]        r_len, w_len_nxt;
    logic              r_req_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum, w_sum_nxt;
`endif

    logic w_byte_ev;
    logic w_req_rise;
    logic w_last;

    strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (byte_strobe),
        .o_rise  (w_byte_ev)
    );

    // load_req is a host level assumed synchronous to clk; only its edge is tracked
    assign w_req_rise = load_req & ~r_req_d;
    assign w_last     = (r_count == (r_len - 9'd1));

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_hold_nxt  = r_hold;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_count_nxt = r_count;
        w_len_nxt   = r_len;
`ifdef LOADER_CHECKSUM_EN
        w_sum_nxt   = r_sum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (load_req) begin
                    w_state_nxt = ST_LEN;
                    w_hold_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_count_nxt = 9'd0;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt   = 8'h00;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LEN: begin
                // Abort has priority over a byte arriving in the same cycle
                if (!load_req) begin
                    w_state_nxt = ST_ERR;
                    w_hold_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_byte_ev) begin
                    w_len_nxt   = (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_DATA: begin
                if (!load_req) begin
                    w_state_nxt = ST_ERR;
                    w_hold_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_byte_ev) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = ADDR_W'(r_count & ADDR_MASK);
                    w_wdata_nxt = byte_in;
                    w_count_nxt = r_count + 9'd1;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt   = sum8(r_sum, byte_in);
                    if (w_last) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
`else
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                        w_hold_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
`endif
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (!load_req) begin
                    w_state_nxt = ST_ERR;
                    w_hold_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_byte_ev) begin
                    // Data sum plus its two's complement is zero mod 256
                    if (sum8(r_sum, byte_in) == 8'h00) begin
                        w_state_nxt = ST_DONE;
                        w_hold_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_hold_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_CHECK;
                end
            end
`endif
            ST_DONE: begin
                // A new session needs a fresh rising edge of load_req
                if (w_req_rise) begin
                    w_state_nxt = ST_LEN;
                    w_hold_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_count_nxt = 9'd0;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt   = 8'h00;
`endif
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_ERR: begin
                // CPU stays held in IDLE until a later load succeeds
                if (!load_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    // State, session counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= 9'd0;
            r_len   <= 9'd0;
            r_req_d <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= 8'h00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_count <= w_count_nxt;
            r_len   <= w_len_nxt;
            r_req_d <= load_req;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= w_sum_nxt;
`endif
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_hold  = r_hold;
    assign load_done = r_done;
    assign load_err  = r_err;

endmodule
